// File: rtl/tick_rate_controller.sv
// ---------------------------------------------------------------------------
// tick_rate_controller
//
// Purpose:
//   Selects one tap of the divider's decade clock bus (bit 6 = 1 MHz ...
//   bit 0 = 1 Hz) at run time and turns each rising edge of that tap into a
//   single-cycle `tick` enable in the CLK domain. Rate changes go through a
//   req/ack handshake and only take effect on period boundaries, so no tick
//   is lost or duplicated across a switch. No divided clock is used as a
//   clock.
//
// Ports:
//   CLK        in   system clock, the only clock
//   RST        in   synchronous active-high reset
//   clock      in   [NTAPS-1:0] divider tap bus, asynchronous to CLK
//   sel_req    in   rate-change request (level, held until sel_ack)
//   sel_idx    in   [2:0] requested tap index, captured at acceptance
//   sel_ack    out  one-cycle completion pulse
//   sel_err    out  one-cycle pulse alongside sel_ack for an invalid index
//   busy       out  high while a request is being handled
//   cur_idx    out  [2:0] currently active tap index
//   tick       out  one-cycle enable per selected-tap rising edge
//   tick_cnt   out  [15:0] ticks since the last rate change
//
// Build option:
//   TICK_COUNTER_EN  when defined, tick_cnt counts ticks (wrapping) and is
//                    cleared whenever cur_idx changes; when undefined the
//                    counter is omitted and tick_cnt reads 0.
//
// States:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | no request pending, ticks from cur_idx
//   ALIGN     | waiting for the old tap's next rise (last old-rate tick)
//   SWITCH    | cur_idx already moved; waiting for the new tap's first rise
//   ACK       | pulse sel_ack/sel_err for the same-index and error paths
//   WAIT_LOW  | hold until sel_req drops so a held request cannot retrigger
// ---------------------------------------------------------------------------
module tick_rate_controller #(
    parameter int NTAPS       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_IDX   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NTAPS-1:0] clock,
    input  logic             sel_req,
    input  logic [2:0]       sel_idx,
    output logic             sel_ack,
    output logic             sel_err,
    output logic             busy,
    output logic [2:0]       cur_idx,
    output logic             tick,
    output logic [15:0]      tick_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_SWITCH,
        ST_ACK,
        ST_WAIT_LOW
    } state_t;

    // The edge pipeline is SYNC_STAGES sync flops, one edge register and one
    // history register. Events stay masked until the history register holds
    // a real post-reset sample, so a tap already high at release is not
    // mistaken for a rising edge.
    localparam int WARM_CYCLES = SYNC_STAGES + 2;
    localparam int WARM_W      = $clog2(WARM_CYCLES + 1);
    localparam logic [3:0] NTAPS_W = 4'(NTAPS);
    localparam logic [2:0] RST_IDX = 3'(RESET_IDX);

    logic [NTAPS-1:0]  sync_q [SYNC_STAGES];
    logic [NTAPS-1:0]  edge_q;
    logic [NTAPS-1:0]  prev_q;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;
    logic [NTAPS-1:0]  rise;
    logic [7:0]        rise_pad;
    logic              rise_cur;
    logic              idx_invalid;

    state_t            state;
    logic [2:0]        nxt_idx;
    logic              err_q;
    logic              acked_q;

    // ------------------------------------------------------------------
    // Tap synchronisers, edge detection and warm-up down-counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            edge_q   <= '0;
            prev_q   <= '0;
            warm_cnt <= WARM_W'(WARM_CYCLES);
        end else begin
            sync_q[0] <= clock;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            edge_q <= sync_q[SYNC_STAGES-1];
            prev_q <= edge_q;
            if (warm_cnt != '0) begin
                warm_cnt <= warm_cnt - 1'b1;
            end
        end
    end

    assign warm_done   = (warm_cnt == '0);
    assign rise        = edge_q & ~prev_q & {NTAPS{warm_done}};
    // Padding to 8 bits keeps the 3-bit index in range for any NTAPS <= 8.
    assign rise_pad    = 8'(rise);
    assign rise_cur    = rise_pad[cur_idx];
    assign idx_invalid = ({1'b0, sel_idx} >= NTAPS_W);

    // ------------------------------------------------------------------
    // Rate-change FSM with registered outputs.
    // tick always follows rise[cur_idx]: in ALIGN that is the old tap, and
    // because cur_idx moves on the same edge as the last old tick, SWITCH
    // only ever sees the new tap. A new-tap rise coincident with the final
    // old-tap rise is consumed by ALIGN, so SWITCH waits for the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            nxt_idx <= RST_IDX;
            err_q   <= 1'b0;
            acked_q <= 1'b0;
            sel_ack <= 1'b0;
            sel_err <= 1'b0;
            busy    <= 1'b0;
            cur_idx <= RST_IDX;
            tick    <= 1'b0;
        end else begin
            sel_ack <= 1'b0;
            sel_err <= 1'b0;
            tick    <= rise_cur;
            case (state)
                ST_IDLE: begin
                    if (sel_req) begin
                        nxt_idx <= sel_idx;
                        busy    <= 1'b1;
                        acked_q <= 1'b0;
                        if (idx_invalid) begin
                            err_q <= 1'b1;
                            state <= ST_ACK;
                        end else if (sel_idx == cur_idx) begin
                            err_q <= 1'b0;
                            state <= ST_ACK;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (rise_cur) begin
                        cur_idx <= nxt_idx;
                        state   <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    // Ack lands in the same cycle as the first new-rate tick.
                    if (rise_cur) begin
                        sel_ack <= 1'b1;
                        acked_q <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!acked_q) begin
                        sel_ack <= 1'b1;
                        sel_err <= err_q;
                    end
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!sel_req) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional tick counter
    // ------------------------------------------------------------------
`ifdef TICK_COUNTER_EN
    logic cur_change;

    // cur_idx only changes on the ALIGN boundary edge; clearing there wins
    // over the final old-rate tick so the first new-rate tick reads 1.
    assign cur_change = (state == ST_ALIGN) && rise_cur;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (cur_change) begin
            tick_cnt <= '0;
        end else if (rise_cur) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
`else
    assign tick_cnt = '0;
`endif

endmodule
